// File: rtl/trig_timestamper_if.sv
// Event readout channel of the trigger timestamper: FWFT head event plus fill level.
// Valid/ready: the head event is transferred on a rising clock edge where io_evt_valid and io_evt_ready are both 1.
interface trig_timestamper_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 io_evt_valid;
  logic                 io_evt_ready;
  logic                 io_evt_channel;
  logic [CNT_WIDTH-1:0] io_evt_time;
  logic [LW-1:0]        io_level;

  modport master (
    output io_evt_valid,
    output io_evt_channel,
    output io_evt_time,
    output io_level,
    input  io_evt_ready
  );

  modport slave (
    input  io_evt_valid,
    input  io_evt_channel,
    input  io_evt_time,
    input  io_level,
    output io_evt_ready
  );
endinterface

// File: rtl/trig_timestamper.sv
// Synchronises two asynchronous trigger pins, timestamps their rising edges against a
// free-running timebase and queues {channel, time} events in a small FWFT queue.
module trig_timestamper #(
  parameter int CNT_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 io_mainClk,
  input  logic                 io_asyncResetn,
  input  logic [1:0]           io_trigsIn,
  input  logic                 io_enable,
  input  logic                 io_clear,
  output logic                 io_overflow,
  trig_timestamper_if.master   evt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  synced;
  logic [1:0]                  edge_hist;
  logic [1:0]                  edge_det;
  logic [CNT_WIDTH-1:0]        timebase;
  logic [1:0]                  hold_valid;
  logic [1:0][CNT_WIDTH-1:0]   hold_time;
  logic                        last_push_ch0;
  logic [CNT_WIDTH:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [LW-1:0]               count;
  logic                        full;
  logic                        empty;
  logic                        sel1;
  logic                        push;
  logic                        pop;
  logic [1:0]                  pushed;

  assign synced = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  // Channel 1 wins only when channel 0 has nothing held or already got the previous slot.
  always_comb begin
    edge_det = synced & ~edge_hist & {2{io_enable}};
    full     = (count == FULL_LEVEL);
    empty    = (count == '0);
    sel1     = hold_valid[1] & (~hold_valid[0] | last_push_ch0);
    push     = (|hold_valid) & ~full;
    pushed   = 2'b00;
    if (push) pushed = sel1 ? 2'b10 : 2'b01;
    pop      = ~empty & evt.io_evt_ready;
  end

  // Synchronisers and edge history survive io_clear so a level held across a clear is not re-detected.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sync_q    <= '0;
      edge_hist <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], io_trigsIn[i]};
      end
      edge_hist <= synced;
    end
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      timebase      <= '0;
      hold_valid    <= '0;
      hold_time     <= '0;
      last_push_ch0 <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      io_overflow   <= 1'b0;
    end else if (io_clear) begin
      timebase      <= '0;
      hold_valid    <= '0;
      hold_time     <= '0;
      last_push_ch0 <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      io_overflow   <= 1'b0;
    end else begin
      if (io_enable) timebase <= timebase + CNT_WIDTH'(1);
      last_push_ch0 <= pushed[0];
      for (int i = 0; i < 2; i++) begin
        if (edge_det[i] && (!hold_valid[i] || pushed[i])) begin
          hold_valid[i] <= 1'b1;
          hold_time[i]  <= timebase;
        end else if (edge_det[i]) begin
          io_overflow <= 1'b1;
        end else if (pushed[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge io_mainClk) begin
    if (push && !io_clear) mem[wr_ptr] <= {sel1, hold_time[sel1]};
  end

  assign evt.io_evt_valid   = ~empty;
  assign evt.io_evt_channel = empty ? 1'b0 : mem[rd_ptr][CNT_WIDTH];
  assign evt.io_evt_time    = empty ? '0 : mem[rd_ptr][CNT_WIDTH-1:0];
  assign evt.io_level       = count;
endmodule

// File: tb/tb_trig_timestamper.sv
// Bench for trig_timestamper: scenario tasks drive pins and push expected events;
// a negedge monitor pops and compares every event the consumer accepts.
module tb_trig_timestamper;
  localparam int CW = 16;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    trigs = 2'b00;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          overflow;
  logic [CW-1:0] model_tb;
  logic [CW:0]   exp_q[$];
  logic [CW:0]   mon_exp;
  int            checks = 0;
  int            failures = 0;

  trig_timestamper_if #(.CNT_WIDTH(CW), .FIFO_DEPTH(FD)) evt_if ();

  trig_timestamper #(.CNT_WIDTH(CW), .FIFO_DEPTH(FD), .SYNC_STAGES(2)) dut (
    .io_mainClk     (clk),
    .io_asyncResetn (rst_n),
    .io_trigsIn     (trigs),
    .io_enable      (enable),
    .io_clear       (clear),
    .io_overflow    (overflow),
    .evt            (evt_if)
  );

  always #5 clk = ~clk;

  // Reference timebase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      model_tb <= '0;
    else if (clear)  model_tb <= '0;
    else if (enable) model_tb <= model_tb + 16'd1;
  end

  // Scoreboard: an accepted head event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && evt_if.io_evt_valid && evt_if.io_evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL evt_unexpected: got ch=%0d time=%h, required no event",
                 evt_if.io_evt_channel, evt_if.io_evt_time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({evt_if.io_evt_channel, evt_if.io_evt_time} !== mon_exp) begin
          failures++;
          $display("FAIL evt_data: got ch=%0d time=%h, required ch=%0d time=%h",
                   evt_if.io_evt_channel, evt_if.io_evt_time, mon_exp[CW], mon_exp[CW-1:0]);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise pins; returns in the detection cycle, recording expected events.
  task automatic rise(input logic [1:0] mask, input bit expect_it);
    trigs = trigs | mask;
    cyc(2);
    if (expect_it && mask[0]) exp_q.push_back({1'b0, model_tb});
    if (expect_it && mask[1]) exp_q.push_back({1'b1, model_tb});
  endtask

  task automatic fall(input logic [1:0] mask);
    trigs = trigs & ~mask;
    cyc(3);
  endtask

  task automatic pulse(input logic [1:0] mask, input bit expect_it);
    rise(mask, expect_it);
    cyc(1);
    fall(mask);
  endtask

  task automatic wait_model(input logic [CW-1:0] t);
    int n;
    n = 0;
    while (model_tb !== t && n < 70000) begin
      cyc(1);
      n++;
    end
    checks++;
    if (model_tb !== t) begin
      failures++;
      $display("FAIL wait_model: timebase %h, required %h", model_tb, t);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    evt_if.io_evt_ready = 1'b1;
    while (evt_if.io_level !== '0 && n < 40) begin
      cyc(1);
      n++;
    end
    evt_if.io_evt_ready = 1'b0;
    checks++;
    if (evt_if.io_level !== '0 || evt_if.io_evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: level=%0d valid=%0d, required 0 and 0", evt_if.io_level, evt_if.io_evt_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_missing: %0d expected events not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    evt_if.io_evt_ready = 1'b0;
    #2 rst_n = 1'b0;
    cyc(3);
    checks++;
    if ({evt_if.io_evt_valid, evt_if.io_evt_channel, evt_if.io_evt_time, evt_if.io_level, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0d ch=%0d time=%h level=%0d ovf=%0d, required all 0",
               evt_if.io_evt_valid, evt_if.io_evt_channel, evt_if.io_evt_time, evt_if.io_level, overflow);
    end
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_single();
    wait_model(16'h000E);
    rise(2'b01, 1'b1);
    cyc(1);
    checks++;
    if (evt_if.io_evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: valid=%0d one cycle after detection, required 0", evt_if.io_evt_valid);
    end
    cyc(1);
    checks++;
    if (evt_if.io_evt_valid !== 1'b1 || evt_if.io_level !== 3'd1) begin
      failures++;
      $display("FAIL single_valid: valid=%0d level=%0d, required 1 and 1", evt_if.io_evt_valid, evt_if.io_level);
    end
    checks++;
    if (evt_if.io_evt_channel !== 1'b0 || evt_if.io_evt_time !== 16'h0010) begin
      failures++;
      $display("FAIL single_head: ch=%0d time=%h, required 0 and 0010", evt_if.io_evt_channel, evt_if.io_evt_time);
    end
    evt_if.io_evt_ready = 1'b1;
    cyc(1);
    evt_if.io_evt_ready = 1'b0;
    checks++;
    if (evt_if.io_evt_valid !== 1'b0 || evt_if.io_level !== 3'd0) begin
      failures++;
      $display("FAIL single_pop: valid=%0d level=%0d, required 0 and 0", evt_if.io_evt_valid, evt_if.io_level);
    end
    fall(2'b01);
  endtask

  task automatic test_simultaneous();
    wait_model(16'h00FE);
    rise(2'b11, 1'b1);
    cyc(2);
    checks++;
    if (evt_if.io_level !== 3'd1 || evt_if.io_evt_channel !== 1'b0) begin
      failures++;
      $display("FAIL simul_first: level=%0d ch=%0d, required 1 and 0", evt_if.io_level, evt_if.io_evt_channel);
    end
    cyc(1);
    checks++;
    if (evt_if.io_level !== 3'd2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL simul_second: level=%0d ovf=%0d, required 2 and 0", evt_if.io_level, overflow);
    end
    fall(2'b11);
    drain();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) begin
      pulse(2'b01, 1'b1);
      cyc(4);
    end
    checks++;
    if (evt_if.io_level !== 3'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full: level=%0d ovf=%0d, required 4 and 0", evt_if.io_level, overflow);
    end
    pulse(2'b01, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: ovf=%0d, required 1", overflow);
    end
    drain();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%0d after drain, required 1", overflow);
    end
  endtask

  task automatic test_clear();
    pulse(2'b01, 1'b1);
    pulse(2'b10, 1'b1);
    checks++;
    if (evt_if.io_level !== 3'd2) begin
      failures++;
      $display("FAIL clear_pre: level=%0d, required 2", evt_if.io_level);
    end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    exp_q.delete();
    checks++;
    if (evt_if.io_level !== 3'd0 || evt_if.io_evt_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: level=%0d valid=%0d ovf=%0d, required 0 0 0",
               evt_if.io_level, evt_if.io_evt_valid, overflow);
    end
    rise(2'b01, 1'b1);
    cyc(2);
    checks++;
    if (evt_if.io_evt_time !== 16'h0002) begin
      failures++;
      $display("FAIL clear_timebase: time=%h, required 0002", evt_if.io_evt_time);
    end
    fall(2'b01);
    drain();
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    pulse(2'b11, 1'b0);
    cyc(3);
    checks++;
    if (evt_if.io_level !== 3'd0 || evt_if.io_evt_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL disabled: level=%0d valid=%0d ovf=%0d, required 0 0 0",
               evt_if.io_level, evt_if.io_evt_valid, overflow);
    end
    enable = 1'b1;
    pulse(2'b10, 1'b1);
    drain();
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    wait_model(16'hFFFD);
    trigs[0] = 1'b1;
    cyc(2);
    exp_q.push_back({1'b0, model_tb});
    trigs[1] = 1'b1;
    cyc(2);
    exp_q.push_back({1'b1, model_tb});
    checks++;
    if (evt_if.io_evt_time !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_head: time=%h, required FFFF", evt_if.io_evt_time);
    end
    fall(2'b11);
    checks++;
    if (evt_if.io_level !== 3'd2) begin
      failures++;
      $display("FAIL wrap_level: level=%0d, required 2", evt_if.io_level);
    end
    evt_if.io_evt_ready = 1'b1;
    cyc(1);
    evt_if.io_evt_ready = 1'b0;
    checks++;
    if (evt_if.io_evt_channel !== 1'b1 || evt_if.io_evt_time !== 16'h0001) begin
      failures++;
      $display("FAIL wrap_second: ch=%0d time=%h, required 1 and 0001", evt_if.io_evt_channel, evt_if.io_evt_time);
    end
    drain();
  endtask

  task automatic test_async_reset();
    pulse(2'b01, 1'b1);
    pulse(2'b10, 1'b1);
    pulse(2'b01, 1'b1);
    checks++;
    if (evt_if.io_level !== 3'd3) begin
      failures++;
      $display("FAIL areset_pre: level=%0d, required 3", evt_if.io_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({evt_if.io_evt_valid, evt_if.io_evt_channel, evt_if.io_evt_time, evt_if.io_level, overflow} !== '0) begin
      failures++;
      $display("FAIL areset_outputs: valid=%0d ch=%0d time=%h level=%0d ovf=%0d, required all 0",
               evt_if.io_evt_valid, evt_if.io_evt_channel, evt_if.io_evt_time, evt_if.io_level, overflow);
    end
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    rise(2'b01, 1'b1);
    cyc(2);
    checks++;
    if (evt_if.io_evt_valid !== 1'b1 || evt_if.io_evt_time !== 16'h0002) begin
      failures++;
      $display("FAIL areset_restart: valid=%0d time=%h, required 1 and 0002", evt_if.io_evt_valid, evt_if.io_evt_time);
    end
    fall(2'b01);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_clear();
    test_enable_off();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
